// File: rtl/adc_dig_pkg.sv
// Shared types and thermometer helpers for the ADC digital back-end conditioners.
// Helpers work on words zero-extended to THERMO_MAX_W bits.
package adc_dig_pkg;

    localparam int THERMO_MAX_W = 32;

    typedef enum logic {
        NORMAL = 1'b0,
        OVR    = 1'b1
    } ovr_state_t;

    // A word of the form 0...01...1 has no bit in common with itself plus one.
    function automatic logic is_thermo(input logic [THERMO_MAX_W-1:0] word);
        logic [THERMO_MAX_W-1:0] inc;
        inc = word + 1'b1;
        return (word & inc) == '0;
    endfunction

    function automatic logic [THERMO_MAX_W-1:0] pop_to_thermo(input logic [THERMO_MAX_W-1:0] word);
        logic [THERMO_MAX_W-1:0] res;
        res = '0;
        for (int i = 0; i < THERMO_MAX_W; i++) begin
            if (word[i]) res = {res[THERMO_MAX_W-2:0], 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/thermo_majority3.sv
// 3-input majority bubble filter across neighbouring comparator bits.
// Below bit 0 reads as 1 and above the top bit reads as 0.
module thermo_majority3 #(
    parameter int WIDTH = 14
) (
    input  logic [WIDTH-1:0] i_s,
    output logic [WIDTH-1:0] o_c
);

    logic [WIDTH+1:0] w_pad;

    assign w_pad = {1'b0, i_s, 1'b1};

    for (genvar i = 0; i < WIDTH; i++) begin : g_maj
        assign o_c[i] = (w_pad[i]   & w_pad[i+1]) |
                        (w_pad[i]   & w_pad[i+2]) |
                        (w_pad[i+1] & w_pad[i+2]);
    end

endmodule

// File: rtl/adc_thermo_cond.sv
// Thermometer conditioner for one pipelined-ADC stage: capture, majority filter,
// validate/substitute, error statistics and overrange hysteresis. WIDTH up to 31.
//   state  | meaning
//   NORMAL | dout not in overrange; counting consecutive all-ones outputs
//   OVR    | overrange flagged; counting consecutive non-all-ones outputs
module adc_thermo_cond
    import adc_dig_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int ERR_CNT_W = 16,
    parameter int OVR_LIMIT = 4
) (
    input  logic                 clk_p1_delay,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 hold_en,
    input  logic                 clr_cnt,
    output logic [WIDTH-1:0]     dout,
    output logic                 code_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 ovr
);

    logic [WIDTH-1:0]        r_s, r_c, r_dout, r_last_good, w_c;
    logic                    r_bub, r_code_err, r_ovr;
    logic [ERR_CNT_W-1:0]    r_err_cnt;
    logic [7:0]              r_run, w_run_inc;
    ovr_state_t              r_state;
    logic [THERMO_MAX_W-1:0] w_c_ext, w_pop;
    logic                    w_valid, w_dout_ones, w_run_hit, w_unused;

    thermo_majority3 #(.WIDTH(WIDTH)) u_maj (
        .i_s (r_s),
        .o_c (w_c)
    );

    always_comb begin
        w_c_ext = '0;
        w_c_ext[WIDTH-1:0] = r_c;
    end

    assign w_valid     = is_thermo(w_c_ext);
    assign w_pop       = pop_to_thermo(w_c_ext);
    assign w_unused    = ^{1'b0, w_pop[THERMO_MAX_W-1:WIDTH]};
    assign w_dout_ones = &r_dout;
    assign w_run_inc   = r_run + 8'd1;
    assign w_run_hit   = (w_run_inc == 8'(OVR_LIMIT));

    always_ff @(posedge clk_p1_delay) begin
        if (rst) begin
            r_s         <= '0;
            r_c         <= '0;
            r_bub       <= 1'b0;
            r_dout      <= '0;
            r_last_good <= '0;
            r_code_err  <= 1'b0;
        end else begin
            r_s        <= din;
            r_c        <= w_c;
            r_bub      <= (w_c != r_s);
            r_code_err <= r_bub | ~w_valid;
            if (w_valid) begin
                r_dout      <= r_c;
                r_last_good <= r_c;
            end else if (hold_en) begin
                r_dout <= r_last_good;
            end else begin
                r_dout <= w_pop[WIDTH-1:0];
            end
        end
    end

    // Counts the registered code_err, so it trails code_err by one edge.
    always_ff @(posedge clk_p1_delay) begin
        if (rst || clr_cnt) begin
            r_err_cnt <= '0;
        end else if (r_code_err && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_p1_delay) begin
        if (rst) begin
            r_state <= NORMAL;
            r_run   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            case (r_state)
                NORMAL: begin
                    if (!w_dout_ones) begin
                        r_run <= '0;
                    end else if (w_run_hit) begin
                        r_state <= OVR;
                        r_run   <= '0;
                        r_ovr   <= 1'b1;
                    end else begin
                        r_run <= w_run_inc;
                    end
                end
                OVR: begin
                    if (w_dout_ones) begin
                        r_run <= '0;
                    end else if (w_run_hit) begin
                        r_state <= NORMAL;
                        r_run   <= '0;
                        r_ovr   <= 1'b0;
                    end else begin
                        r_run <= w_run_inc;
                    end
                end
                default: begin
                    r_state <= NORMAL;
                    r_run   <= '0;
                    r_ovr   <= 1'b0;
                end
            endcase
        end
    end

    assign dout     = r_dout;
    assign code_err = r_code_err;
    assign err_cnt  = r_err_cnt;
    assign ovr      = r_ovr;

endmodule

// File: doc/adc_thermo_cond.md
# adc_thermo_cond

Per-stage thermometer conditioner for the pipelined ADC digital back-end. It samples the raw comparator word of one sub-ADC stage on `clk_p1_delay` and removes single-bit bubbles with a 3-input majority filter. Codes that are still non-monotonic are replaced, and the block keeps bubble and overrange statistics. The clean thermometer word feeds the stage's thermometer-to-binary encoder and delay-alignment chain, which precedes the 13-bit error-correction adder. Instances: t1 (WIDTH 14), t3 (WIDTH 6), t5 (WIDTH 15).

## Interface
Parameters:
- `WIDTH`, default 14, comparator count of the stage.
- `ERR_CNT_W`, default 16, error counter width.
- `OVR_LIMIT`, default 4, consecutive all-ones outputs needed to enter, and all-ones-free outputs needed to leave, overrange; range 1..255.

Ports:
- `clk_p1_delay`  in  1  stage clock.
- `rst`  in  1  reset: synchronous, active-high; clock `clk_p1_delay`.
- `din`  in  WIDTH  raw comparator outputs; bit 0 = lowest threshold.
- `hold_en`  in  1  1: substitute last good code on invalid word; 0: substitute popcount thermometer.
- `clr_cnt`  in  1  synchronous clear of `err_cnt`.
- `dout`  out  WIDTH  conditioned thermometer code.
- `code_err`  out  1  high in the same cycle as the `dout` that was corrected or substituted.
- `err_cnt`  out  ERR_CNT_W  saturating count of `code_err` cycles.
- `ovr`  out  1  overrange flag.

## Operation
- **S0 (capture).** `s <= din`.
- **S1 (majority).**
  - `c[i] = maj(s[i-1], s[i], s[i+1])`, with `s[-1] = 1` and `s[WIDTH] = 0`.
  - Register `c`.
  - Register `bub = (c != s)`.
- **S2 (validate).**
  - `c` is valid iff it has the form `0...01...1`; all-zero and all-ones are valid.
  - If valid: `dout <= c` and `last_good <= c`.
  - If invalid and `hold_en = 1`: `dout <= last_good`.
  - If invalid and `hold_en = 0`: `dout <=` a thermometer with its lowest popcount(`c`) bits set.
  - In both invalid cases `last_good` is unchanged.
  - `code_err <= bub | invalid`.
- **`err_cnt`.**
  - Increments by 1 on each S2 edge that sets `code_err` to 1.
  - Saturates at 2^ERR_CNT_W − 1; it never wraps.
  - `clr_cnt` forces it to 0 and has priority over a simultaneous increment.
- **Overrange FSM (states `NORMAL`, `OVR`), with run counter `run` 8 bits wide.** The FSM evaluates the registered `dout` each edge.
  - `NORMAL`: if `dout` is all-ones, `run` increments; otherwise `run` clears to 0. When the incremented value reaches `OVR_LIMIT`, go to `OVR`, clear `run`, and set `ovr <= 1`.
  - `OVR`: if `dout` is not all-ones, `run` increments; otherwise `run` clears to 0. When the incremented value reaches `OVR_LIMIT`, go to `NORMAL`, clear `run`, and set `ovr <= 0`.
- **Reset.** The following all go to 0: `s`, `c`, `bub`, `dout`, `last_good`, `code_err`, `err_cnt`, `run`, `ovr`. The FSM returns to `NORMAL`.
  - Reset takes effect mid-stream on the next edge.
  - Data in flight is discarded.
  - `hold_en = 1` directly after reset substitutes 0.

## Timing
- Latency is 3 edges: `din` sampled at edge N appears on `dout` and `code_err` after edge N+2. It is stable for the cycle following N+2.
- `err_cnt` reflects a `code_err` one edge later than the `code_err` itself.
- `ovr`:
  - Rises after the edge at which the `OVR_LIMIT`-th consecutive all-ones `dout` is evaluated. That is `OVR_LIMIT` edges after `dout` first becomes all-ones.
  - Falls symmetrically.
- Throughput is one word per cycle with no stalls and no handshake; downstream samples every `clk_p1_delay` edge.
- `hold_en` and `clr_cnt` are sampled each edge with no latency beyond their own register.

## Structure
- Shared package `adc_dig_pkg`:
  - FSM state enum `ovr_state_t {NORMAL, OVR}`.
  - Function `is_thermo(word)`.
  - Function `pop_to_thermo(word)`.
  - These are reused by the t2/t4 instance on `clk_p2_delay`.
- Sub-module `thermo_majority3`: combinational, parameterized by WIDTH, implements the S1 majority with edge padding.
- Everything else lives in `adc_thermo_cond`.

## Test plan
All scenarios use WIDTH=14, ERR_CNT_W=4, OVR_LIMIT=4.
- **Reset.** `rst` = 1 for 2 edges with `din` = 14'h3FFF → `dout` = 0, `code_err` = 0, `err_cnt` = 0, `ovr` = 0.
- **Clean code.** `din` = 14'h00FF → `dout` = 14'h00FF after edge 3, `code_err` = 0.
- **Bubble correction.**
  - `din` = 14'h00FB → `dout` = 14'h00FF, `code_err` = 1, and `err_cnt` = 1 one edge later.
  - 20 consecutive bubbles → `err_cnt` saturates at 15.
  - `clr_cnt` = 1 together with a bubble → `err_cnt` = 0.
- **Invalid code.** Prime with 14'h003F, then apply 14'h0F0F.
  - `hold_en` = 1 → `dout` = 14'h003F.
  - `hold_en` = 0 → `dout` = 14'h00FF.
  - `code_err` = 1 in both cases.
- **Overrange.**
  - 6 × 14'h3FFF → `ovr` = 1 exactly 4 edges after `dout` first reads 14'h3FFF.
  - Then 14'h0001 repeated → `ovr` = 0 after 4 non-all-ones outputs.
  - A single 14'h0001 inside an all-ones run restarts the count.
- **Reset mid-stream.** Assert `rst` during a bubble burst with `ovr` = 1 → all outputs 0 on the next edge, FSM in `NORMAL`, no stale word emitted after release.
